alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue/sequencing controller in front of the execute-stage ALU. Accepts decoded instructions from decode with a valid/ready handshake and registers operands into the ALU. Holds the ALU for multi-cycle MUL. Resolves branch outcomes and emits a one-cycle pipeline flush. Reports writeback completion and counts stall cycles for performance monitoring.

Parameters:
DATA_W, 32, operand/result width (register file range)
OP_W, 8, opcode width
RD_W, 5, destination register index width
MUL_LAT, 4, ALU cycles for MUL (opcode 0x02); legal range 2..15
STALL_CNT_W, 16, width of the saturating stall counter

Ports:
clock  in  1  core clock
reset_c  in  1  asynchronous, active-high reset
dec_valid  in  1  decode presents an instruction
dec_ready  out  1  controller accepts this cycle
dec_opcode  in  OP_W  decoded opcode
dec_rd  in  RD_W  destination register
dec_val1  in  DATA_W  operand 1
dec_val2  in  DATA_W  operand 2
alu_stall  in  1  downstream (mem stage) stall
alu_branch_taken  in  1  registered ALU branch-taken flag
alu_issue_valid  out  1  one-cycle pulse: ALU op launched
alu_instr  out  OP_W  opcode driven to ALU, held until next issue
alu_val1  out  DATA_W  operand 1 to ALU, held
alu_val2  out  DATA_W  operand 2 to ALU, held
alu_rd  out  RD_W  destination to ALU, held
wb_valid  out  1  one-cycle pulse: register result ready for writeback
wb_rd  out  RD_W  destination of completing op
flush  out  1  one-cycle pulse: discard younger fetch/decode instructions
illegal_op  out  1  one-cycle pulse: unsupported opcode consumed
busy  out  1  state != IDLE
stall_cycles  out  STALL_CNT_W  saturating count of cycles with alu_stall=1

Behaviour:
- Opcode classes:
  - ALU_WB = 0x00 ADD, 0x01 SUB.
  - MUL = 0x02.
  - MEM = 0x10..0x13.
  - SYS = 0x32 TLBWRITE.
  - BR = 0x30 BEQ, 0x31 JUMP, 0x33 IRET.
  - Any other opcode is illegal.
- FSM states: IDLE, MUL_WAIT, BR_WAIT. Reset (async, any cycle, including mid-MUL or mid-branch) forces:
  - state = IDLE, counter = 0;
  - all outputs 0, stall_cycles = 0.
- dec_ready = (state==IDLE) && !alu_stall. This is combinational; it never depends on dec_valid.
- Accept = dec_valid && dec_ready. On accept of a legal op, in the next cycle:
  - alu_instr/val1/val2/rd hold the registered dec_* values;
  - alu_issue_valid = 1 for exactly that cycle.
- ALU_WB: state stays IDLE; wb_valid=1, wb_rd=alu_rd one cycle after alu_issue_valid (issue+2 after accept). Back-to-back accepts allowed.
- MEM, SYS: issued like ALU_WB; no wb_valid (mem stage owns MEM writeback).
- MUL: next state MUL_WAIT, counter loaded with MUL_LAT-1.
  - In MUL_WAIT: counter decrements each cycle alu_stall=0 and freezes while alu_stall=1; alu_* outputs held.
  - At counter==0 with alu_stall=0: wb_valid=1, wb_rd=alu_rd that cycle, then IDLE.
  - dec_ready=0 throughout.
- BR: next state BR_WAIT; dec_ready=0.
  - alu_branch_taken is sampled in the first BR_WAIT cycle with alu_stall=0.
  - If taken: flush=1 for the following single cycle.
  - State returns to IDLE in the same cycle as the flush pulse, or the cycle after sampling if not taken.
  - BR ops never assert wb_valid.
- Illegal opcode: consumed (dec_ready honoured). Next cycle illegal_op=1; alu_issue_valid=0; alu_* unchanged; state stays IDLE.
- Simultaneous events:
  - flush and a new accept cannot coincide, because dec_ready=0 in BR_WAIT and flush's own cycle is IDLE with dec_ready live. Decode must drop its instruction when flush=1, so the controller ignores dec_valid during the flush cycle.
  - wb_valid from an ALU_WB op and alu_issue_valid of the next op may coincide.
- stall_cycles: increments each cycle alu_stall=1 and saturates at all-ones. It does not wrap.
- busy is combinational from state.

Test Plan:
- Reset then ADD: dec_opcode=0x00, val1=5, val2=7, rd=3, dec_valid 1 cycle -> alu_issue_valid at T+1 with alu_val1=5/alu_val2=7, wb_valid with wb_rd=3 at T+2; dec_ready stays 1.
- MUL, MUL_LAT=4, rd=9 -> busy and dec_ready=0 for 4 cycles, wb_valid/wb_rd=9 exactly once. Repeat with alu_stall high 2 cycles mid-wait -> wb_valid delayed by 2, stall_cycles=2.
- JUMP (0x31) with alu_branch_taken=1 in BR_WAIT -> single flush pulse, no wb_valid, then accepts next op. BEQ with taken=0 -> no flush, IDLE after 1 BR_WAIT cycle.
- Opcode 0x7F -> illegal_op pulse 1 cycle, alu_issue_valid=0, alu_* retain previous values.
- Assert reset_c asynchronously mid-MUL_WAIT -> all outputs 0 immediately, no wb_valid after release, dec_ready=1 first cycle after release.
- Hold alu_stall=1 for 70000 cycles -> stall_cycles saturates at 0xFFFF; dec_ready=0 throughout.

Source files
------------

// File: rtl/alu_issue_if.sv
// Decode-to-ALU issue bundle: decode handshake, ALU operand and control lines, writeback, flush and status.
// The controller uses the slave modport; the decode/ALU environment uses the master modport.
interface alu_issue_if #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 8,
  parameter int RD_W        = 5,
  parameter int STALL_CNT_W = 16
);
  logic                   dec_valid;
  logic                   dec_ready;
  logic [OP_W-1:0]        dec_opcode;
  logic [RD_W-1:0]        dec_rd;
  logic [DATA_W-1:0]      dec_val1;
  logic [DATA_W-1:0]      dec_val2;
  logic                   alu_stall;
  logic                   alu_branch_taken;
  logic                   alu_issue_valid;
  logic [OP_W-1:0]        alu_instr;
  logic [DATA_W-1:0]      alu_val1;
  logic [DATA_W-1:0]      alu_val2;
  logic [RD_W-1:0]        alu_rd;
  logic                   wb_valid;
  logic [RD_W-1:0]        wb_rd;
  logic                   flush;
  logic                   illegal_op;
  logic                   busy;
  logic [STALL_CNT_W-1:0] stall_cycles;

  modport slave (
    input  dec_valid, dec_opcode, dec_rd, dec_val1, dec_val2, alu_stall, alu_branch_taken,
    output dec_ready, alu_issue_valid, alu_instr, alu_val1, alu_val2, alu_rd,
           wb_valid, wb_rd, flush, illegal_op, busy, stall_cycles
  );

  modport master (
    output dec_valid, dec_opcode, dec_rd, dec_val1, dec_val2, alu_stall, alu_branch_taken,
    input  dec_ready, alu_issue_valid, alu_instr, alu_val1, alu_val2, alu_rd,
           wb_valid, wb_rd, flush, illegal_op, busy, stall_cycles
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: issue registered 1 cycle after accept, MUL holds for MUL_LAT cycles, branches flush.
// dec_ready is low while busy or while alu_stall is high; nothing is accepted during the flush cycle.
module alu_issue_ctrl #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 8,
  parameter int RD_W        = 5,
  parameter int MUL_LAT     = 4,
  parameter int STALL_CNT_W = 16
) (
  input  logic       clock,
  input  logic       reset_c,
  alu_issue_if.slave bus
);

  typedef enum logic [1:0] {IDLE, MUL_WAIT, BR_WAIT} state_e;
  typedef enum logic [2:0] {CL_WB, CL_MUL, CL_ISSUE, CL_BR, CL_ILL} op_class_e;

  localparam logic [OP_W-1:0] OP_ADD    = OP_W'('h00);
  localparam logic [OP_W-1:0] OP_SUB    = OP_W'('h01);
  localparam logic [OP_W-1:0] OP_MUL    = OP_W'('h02);
  localparam logic [OP_W-1:0] OP_MEM0   = OP_W'('h10);
  localparam logic [OP_W-1:0] OP_MEM1   = OP_W'('h11);
  localparam logic [OP_W-1:0] OP_MEM2   = OP_W'('h12);
  localparam logic [OP_W-1:0] OP_MEM3   = OP_W'('h13);
  localparam logic [OP_W-1:0] OP_BEQ    = OP_W'('h30);
  localparam logic [OP_W-1:0] OP_JUMP   = OP_W'('h31);
  localparam logic [OP_W-1:0] OP_TLBWR  = OP_W'('h32);
  localparam logic [OP_W-1:0] OP_IRET   = OP_W'('h33);
  // MUL_LAT is limited to 2..15 so the remaining-cycle count fits in 4 bits.
  localparam logic [3:0]      MUL_CNT_INIT = 4'(MUL_LAT - 1);

  state_e                 state, state_nxt;
  op_class_e              dec_class;
  logic [3:0]             cnt, cnt_nxt;
  logic                   dec_rdy, accept, legal, mul_done, br_sample;
  logic                   issue_q, illegal_q, wb_pend_q, wb_q, flush_q;
  logic [OP_W-1:0]        instr_q;
  logic [DATA_W-1:0]      val1_q, val2_q;
  logic [RD_W-1:0]        rd_q, wb_rd_q;
  logic [STALL_CNT_W-1:0] stall_cnt;

  always_comb begin
    dec_class = CL_ILL;
    case (bus.dec_opcode)
      OP_ADD, OP_SUB:                     dec_class = CL_WB;
      OP_MUL:                             dec_class = CL_MUL;
      OP_MEM0, OP_MEM1, OP_MEM2, OP_MEM3,
      OP_TLBWR:                           dec_class = CL_ISSUE;
      OP_BEQ, OP_JUMP, OP_IRET:           dec_class = CL_BR;
      default:                            dec_class = CL_ILL;
    endcase
  end

  // Held low during reset so every output reads zero while reset_c is asserted.
  assign dec_rdy = (state == IDLE) && !bus.alu_stall && !reset_c;
  assign legal   = (dec_class != CL_ILL);
  // Decode drops its instruction on flush, so a valid seen in the flush cycle is stale.
  assign accept  = bus.dec_valid && dec_rdy && !flush_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mul_done  = 1'b0;
    br_sample = 1'b0;
    case (state)
      IDLE: begin
        if (accept && dec_class == CL_MUL) begin
          state_nxt = MUL_WAIT;
          cnt_nxt   = MUL_CNT_INIT;
        end else if (accept && dec_class == CL_BR) begin
          state_nxt = BR_WAIT;
        end
      end
      MUL_WAIT: begin
        if (!bus.alu_stall) begin
          if (cnt == 4'd0) begin
            mul_done  = 1'b1;
            state_nxt = IDLE;
          end else begin
            cnt_nxt = cnt - 4'd1;
          end
        end
      end
      BR_WAIT: begin
        if (!bus.alu_stall) begin
          br_sample = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset_c) begin
    if (reset_c) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      issue_q   <= 1'b0;
      illegal_q <= 1'b0;
      wb_pend_q <= 1'b0;
      wb_q      <= 1'b0;
      wb_rd_q   <= '0;
      flush_q   <= 1'b0;
      instr_q   <= '0;
      val1_q    <= '0;
      val2_q    <= '0;
      rd_q      <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      issue_q   <= accept && legal;
      illegal_q <= accept && !legal;
      wb_pend_q <= accept && (dec_class == CL_WB);
      wb_q      <= wb_pend_q;
      flush_q   <= br_sample && bus.alu_branch_taken;
      if (wb_pend_q) begin
        wb_rd_q <= rd_q;
      end
      // Illegal ops leave the ALU operand registers untouched.
      if (accept && legal) begin
        instr_q <= bus.dec_opcode;
        val1_q  <= bus.dec_val1;
        val2_q  <= bus.dec_val2;
        rd_q    <= bus.dec_rd;
      end
      if (bus.alu_stall && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  assign bus.dec_ready       = dec_rdy;
  assign bus.alu_issue_valid = issue_q;
  assign bus.alu_instr       = instr_q;
  assign bus.alu_val1        = val1_q;
  assign bus.alu_val2        = val2_q;
  assign bus.alu_rd          = rd_q;
  // MUL completion is reported in its final wait cycle; it can never overlap a pending ALU writeback.
  assign bus.wb_valid        = wb_q | mul_done;
  assign bus.wb_rd           = mul_done ? rd_q : wb_rd_q;
  assign bus.flush           = flush_q;
  assign bus.illegal_op      = illegal_q;
  assign bus.busy            = (state != IDLE);
  assign bus.stall_cycles    = stall_cnt;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed scenarios plus randomized traffic against a transaction-level model,
// with a scoreboard monitor checking every issue, writeback and illegal-op pulse.
module tb_alu_issue_ctrl;
  localparam int DATA_W  = 32;
  localparam int OP_W    = 8;
  localparam int RD_W    = 5;
  localparam int MUL_LAT = 4;
  localparam int SCW     = 16;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] v1;
    logic [31:0] v2;
    logic [4:0]  rd;
  } iss_t;

  logic clock   = 1'b0;
  logic reset_c = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  iss_t       iss_q[$];
  logic [4:0] wb_q[$];
  int         pend_ill = 0;
  iss_t       last_ok;
  iss_t       mon_e;
  int wb_seen = 0, flush_seen = 0;
  int last_wb_cyc = -1, last_ill_cyc = -1, last_flush_cyc = -1, last_acc_cyc = -1;

  // Transaction-level view: remaining unstalled MUL cycles, pending branch, expected flush, stall count.
  int          m_mul = 0;
  bit          m_br = 1'b0;
  bit          m_flush = 1'b0;
  logic [15:0] m_stall = 16'd0;

  logic [7:0] ops [11] = '{8'h00, 8'h01, 8'h02, 8'h10, 8'h11, 8'h12, 8'h13, 8'h32, 8'h30, 8'h31, 8'h33};

  always #5 clock = ~clock;
  always @(posedge clock) cyc_n <= cyc_n + 1;

  alu_issue_if #(.DATA_W(DATA_W), .OP_W(OP_W), .RD_W(RD_W), .STALL_CNT_W(SCW)) bus ();

  alu_issue_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .RD_W(RD_W), .MUL_LAT(MUL_LAT), .STALL_CNT_W(SCW)) dut (
    .clock   (clock),
    .reset_c (reset_c),
    .bus     (bus)
  );

  // 0 = writeback ALU op, 1 = MUL, 2 = issue without writeback, 3 = branch, 4 = illegal
  function automatic int op_class(input logic [7:0] op);
    case (op)
      8'h00, 8'h01:                      return 0;
      8'h02:                             return 1;
      8'h10, 8'h11, 8'h12, 8'h13, 8'h32: return 2;
      8'h30, 8'h31, 8'h33:               return 3;
      default:                           return 4;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: pulse seen with nothing outstanding", name);
  endtask

  task automatic clear_model();
    iss_q.delete();
    wb_q.delete();
    pend_ill  = 0;
    m_mul     = 0;
    m_br      = 1'b0;
    m_flush   = 1'b0;
    m_stall   = 16'd0;
    last_ok.op = 8'h00;
    last_ok.v1 = 32'd0;
    last_ok.v2 = 32'd0;
    last_ok.rd = 5'd0;
  endtask

  // One clock cycle: drive inputs (called just after a rising edge), check handshake/status at the
  // falling edge, record what the controller should have taken, then advance the model.
  task automatic cyc(input bit v, input logic [7:0] op, input logic [4:0] rd, input logic [31:0] a1,
                     input logic [31:0] a2, input bit st, input bit tk, output bit acc);
    bit   exp_rdy, nf;
    int   k;
    iss_t t;
    bus.dec_valid        = v;
    bus.dec_opcode       = op;
    bus.dec_rd           = rd;
    bus.dec_val1         = a1;
    bus.dec_val2         = a2;
    bus.alu_stall        = st;
    bus.alu_branch_taken = tk;
    @(negedge clock);
    exp_rdy = (m_mul == 0) && !m_br && !st;
    chk("dec_ready", 64'(bus.dec_ready), 64'(exp_rdy));
    chk("busy", 64'(bus.busy), 64'((m_mul != 0) || m_br));
    chk("flush", 64'(bus.flush), 64'(m_flush));
    chk("stall_cycles", 64'(bus.stall_cycles), 64'(m_stall));
    acc = v && exp_rdy && !m_flush;
    if (acc) begin
      k = op_class(op);
      last_acc_cyc = cyc_n;
      if (k != 4) begin
        t.op = op; t.v1 = a1; t.v2 = a2; t.rd = rd;
        iss_q.push_back(t);
      end
      if (k <= 1) wb_q.push_back(rd);
      if (k == 4) pend_ill++;
    end
    nf = m_br && !st && tk;
    if (m_br && !st) m_br = 1'b0;
    if (m_mul > 0 && !st) m_mul--;
    if (acc && op_class(op) == 1) m_mul = MUL_LAT;
    if (acc && op_class(op) == 3) m_br = 1'b1;
    m_flush = nf;
    if (st && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input bit st, input bit tk);
    bit acc;
    cyc(1'b0, 8'h00, 5'd0, 32'd0, 32'd0, st, tk, acc);
  endtask

  // Scoreboard monitor: each output pulse consumes the oldest matching expectation.
  always @(negedge clock) begin
    if (!reset_c) begin
      if (bus.alu_issue_valid) begin
        if (iss_q.size() == 0) unexpected("alu_issue_valid");
        else begin
          mon_e = iss_q.pop_front();
          chk("alu_instr", 64'(bus.alu_instr), 64'(mon_e.op));
          chk("alu_val1", 64'(bus.alu_val1), 64'(mon_e.v1));
          chk("alu_val2", 64'(bus.alu_val2), 64'(mon_e.v2));
          chk("alu_rd", 64'(bus.alu_rd), 64'(mon_e.rd));
          last_ok = mon_e;
        end
      end
      if (bus.wb_valid) begin
        wb_seen++;
        last_wb_cyc = cyc_n;
        if (wb_q.size() == 0) unexpected("wb_valid");
        else chk("wb_rd", 64'(bus.wb_rd), 64'(wb_q.pop_front()));
      end
      if (bus.illegal_op) begin
        last_ill_cyc = cyc_n;
        if (pend_ill == 0) unexpected("illegal_op");
        else begin
          pend_ill--;
          chk("illegal_no_issue", 64'(bus.alu_issue_valid), 64'd0);
          chk("illegal_hold_val1", 64'(bus.alu_val1), 64'(last_ok.v1));
          chk("illegal_hold_instr", 64'(bus.alu_instr), 64'(last_ok.op));
        end
      end
      if (bus.flush) begin
        flush_seen++;
        last_flush_cyc = cyc_n;
      end
    end
  end

  initial begin
    bit acc;
    bit saw;
    int a, w0, f0;
    bus.dec_valid = 1'b0; bus.dec_opcode = 8'h00; bus.dec_rd = 5'd0;
    bus.dec_val1 = 32'd0; bus.dec_val2 = 32'd0;
    bus.alu_stall = 1'b0; bus.alu_branch_taken = 1'b0;
    clear_model();
    #3;
    chk("rst_dec_ready", 64'(bus.dec_ready), 64'd0);
    chk("rst_issue", 64'(bus.alu_issue_valid), 64'd0);
    chk("rst_wb", 64'(bus.wb_valid), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_val1", 64'(bus.alu_val1), 64'd0);
    chk("rst_stall_cycles", 64'(bus.stall_cycles), 64'd0);
    @(posedge clock); #1;
    reset_c = 1'b0;

    // ADD: issue at accept+1, writeback at accept+2
    cyc(1'b1, 8'h00, 5'd3, 32'd5, 32'd7, 1'b0, 1'b0, acc);
    a = last_acc_cyc;
    chk("add_issue_valid", 64'(bus.alu_issue_valid), 64'd1);
    chk("add_val1", 64'(bus.alu_val1), 64'd5);
    chk("add_val2", 64'(bus.alu_val2), 64'd7);
    idle(1'b0, 1'b0);
    chk("add_wb_valid", 64'(bus.wb_valid), 64'd1);
    chk("add_wb_rd", 64'(bus.wb_rd), 64'd3);
    idle(1'b0, 1'b0);
    chk("add_wb_cycle", 64'(last_wb_cyc), 64'(a + 2));

    // MUL without stall: writeback in the MUL_LAT-th wait cycle, exactly once
    w0 = wb_seen;
    cyc(1'b1, 8'h02, 5'd9, 32'd6, 32'd7, 1'b0, 1'b0, acc);
    a = last_acc_cyc;
    repeat (6) idle(1'b0, 1'b0);
    chk("mul_wb_cycle", 64'(last_wb_cyc), 64'(a + MUL_LAT));
    chk("mul_wb_once", 64'(wb_seen), 64'(w0 + 1));

    // MUL with two stall cycles mid-wait: writeback slips by two
    w0 = wb_seen;
    cyc(1'b1, 8'h02, 5'd10, 32'd3, 32'd4, 1'b0, 1'b0, acc);
    a = last_acc_cyc;
    idle(1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    repeat (5) idle(1'b0, 1'b0);
    chk("mul_stall_wb_cycle", 64'(last_wb_cyc), 64'(a + MUL_LAT + 2));
    chk("mul_stall_wb_once", 64'(wb_seen), 64'(w0 + 1));
    chk("mul_stall_count", 64'(bus.stall_cycles), 64'd2);

    // JUMP taken: one flush, the op offered in the flush cycle is dropped, the next is taken
    f0 = flush_seen;
    w0 = wb_seen;
    cyc(1'b1, 8'h31, 5'd1, 32'd0, 32'd0, 1'b0, 1'b0, acc);
    a = last_acc_cyc;
    idle(1'b0, 1'b1);
    cyc(1'b1, 8'h00, 5'd4, 32'd11, 32'd22, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h00, 5'd5, 32'd33, 32'd44, 1'b0, 1'b0, acc);
    repeat (3) idle(1'b0, 1'b0);
    chk("jump_flush_cycle", 64'(last_flush_cyc), 64'(a + 2));
    chk("jump_flush_once", 64'(flush_seen), 64'(f0 + 1));
    chk("jump_wb_only_next_add", 64'(wb_seen), 64'(w0 + 1));

    // BEQ not taken: no flush
    f0 = flush_seen;
    cyc(1'b1, 8'h30, 5'd2, 32'd1, 32'd1, 1'b0, 1'b0, acc);
    repeat (3) idle(1'b0, 1'b0);
    chk("beq_no_flush", 64'(flush_seen), 64'(f0));

    // Illegal opcode after a SUB: pulse one cycle later, ALU outputs keep the SUB
    cyc(1'b1, 8'h01, 5'd7, 32'd100, 32'd200, 1'b0, 1'b0, acc);
    cyc(1'b1, 8'h7F, 5'd8, 32'd1, 32'd2, 1'b0, 1'b0, acc);
    a = last_acc_cyc;
    repeat (3) idle(1'b0, 1'b0);
    chk("illegal_cycle", 64'(last_ill_cyc), 64'(a + 1));

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      int r;
      logic [7:0] op;
      r  = $urandom_range(0, 11);
      op = (r < 11) ? ops[r] : 8'($urandom);
      cyc($urandom_range(0, 3) != 0, op, 5'($urandom), $urandom, $urandom,
          $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), acc);
    end
    repeat (20) idle(1'b0, 1'b0);
    chk("drain_issue_q", 64'(iss_q.size()), 64'd0);
    chk("drain_wb_q", 64'(wb_q.size()), 64'd0);
    chk("drain_illegal", 64'(pend_ill), 64'd0);

    // Asynchronous reset in the middle of a MUL wait
    cyc(1'b1, 8'h02, 5'd12, 32'd9, 32'd9, 1'b0, 1'b0, acc);
    idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    w0 = wb_seen;
    #2 reset_c = 1'b1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_dec_ready", 64'(bus.dec_ready), 64'd0);
    chk("arst_wb", 64'(bus.wb_valid), 64'd0);
    chk("arst_val1", 64'(bus.alu_val1), 64'd0);
    chk("arst_instr", 64'(bus.alu_instr), 64'd0);
    chk("arst_stall_cycles", 64'(bus.stall_cycles), 64'd0);
    clear_model();
    @(posedge clock); #1;
    reset_c = 1'b0;
    repeat (8) idle(1'b0, 1'b0);
    chk("arst_no_wb_after", 64'(wb_seen), 64'(w0));

    // Long stall: counter saturates, never ready
    saw = 1'b0;
    bus.dec_valid = 1'b1;
    bus.dec_opcode = 8'h00;
    bus.alu_stall = 1'b1;
    repeat (70000) begin
      @(negedge clock);
      if (bus.dec_ready) saw = 1'b1;
    end
    @(posedge clock); #1;
    chk("sat_stall_cycles", 64'(bus.stall_cycles), 64'hFFFF);
    chk("sat_never_ready", 64'(saw), 64'd0);
    m_stall = 16'hFFFF;
    repeat (2) idle(1'b1, 1'b0);
    repeat (2) idle(1'b0, 1'b0);
    chk("sat_no_wrap", 64'(bus.stall_cycles), 64'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
